// File: rtl/mem_ctrl_pipe.sv
`default_nettype none
// ============================================================================
// Module   : mem_ctrl_pipe
// Purpose  : Single-port synchronous memory with byte-lane strobes, a
//            self-clearing init sweep and a fully pipelined read path.
// Revision : 1.0
// ============================================================================
module mem_ctrl_pipe #(
    parameter  int unsigned        DATA_W   = 8,
    parameter  int unsigned        ADDR_W   = 8,
    parameter  int unsigned        DEPTH    = 256,
    parameter  int unsigned        RD_LAT   = 2,
    parameter  logic [DATA_W-1:0]  INIT_VAL = '0,
    localparam int unsigned        BE_W     = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ce,
    input  logic              we,
    input  logic [BE_W-1:0]   be,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] datai,
    output logic              ready,
    output logic [DATA_W-1:0] datao,
    output logic              dvalid,
    output logic              err
);

    localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] c_LAST  = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              w_accept;
    logic              w_oor;
    logic              w_wr_ok;
    logic              w_rd_acc;
    logic [DATA_W-1:0] w_rd_word;

    // Stage 0 is captured at the accept edge; stage RD_LAT drives the outputs.
    logic [RD_LAT:0]   vld_q;
    logic [RD_LAT-1:0] oor_q;
    logic [DATA_W-1:0] dat_q [RD_LAT+1];
    logic              wr_oor_q;
    logic              err_q;

    // ------------------------------------------------------------------
    // Init / idle FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_INIT) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == c_LAST) begin
                state_d = ST_IDLE;
            end
        end
    end

    assign ready     = (state_q == ST_IDLE);
    assign w_accept  = ce & ready;
    assign w_oor     = ({1'b0, addr} >= c_DEPTH);
    assign w_wr_ok   = w_accept & we & ~w_oor;
    assign w_rd_acc  = w_accept & ~we;
    assign w_rd_word = w_oor ? '0 : mem_q[addr];

    // ------------------------------------------------------------------
    // Storage: sweep writes during INIT, strobed user writes afterwards
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset_n) begin
            if (state_q == ST_INIT) begin
                mem_q[cnt_q[ADDR_W-1:0]] <= INIT_VAL;
            end else if (w_wr_ok) begin
                for (int i = 0; i < BE_W; i++) begin
                    if (be[i]) begin
                        mem_q[addr][8*i +: 8] <= datai[8*i +: 8];
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read pipeline and error reporting
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vld_q    <= '0;
            oor_q    <= '0;
            wr_oor_q <= 1'b0;
            err_q    <= 1'b0;
            for (int k = 0; k <= RD_LAT; k++) begin
                dat_q[k] <= '0;
            end
        end else begin
            vld_q    <= {vld_q[RD_LAT-1:0], w_rd_acc};
            oor_q[0] <= w_rd_acc & w_oor;
            for (int k = 1; k < RD_LAT; k++) begin
                oor_q[k] <= oor_q[k-1];
            end
            if (w_rd_acc) begin
                dat_q[0] <= w_rd_word;
            end
            // Data only advances behind a valid so datao holds between reads.
            for (int k = 1; k <= RD_LAT; k++) begin
                if (vld_q[k-1]) begin
                    dat_q[k] <= dat_q[k-1];
                end
            end
            wr_oor_q <= w_accept & we & w_oor;
            err_q    <= wr_oor_q | oor_q[RD_LAT-1];
        end
    end

    assign dvalid = vld_q[RD_LAT];
    assign datao  = dat_q[RD_LAT];
    assign err    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_ctrl_pipe
// Purpose  : Directed plus random checks of two mem_ctrl_pipe configurations
//            against a cycle-indexed behavioural scoreboard.
// Revision : 1.0
// ============================================================================
module tb_mem_ctrl_pipe;

    localparam logic [31:0] c_INIT_B = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn [2];
    logic        ce   [2];
    logic        we   [2];
    logic [3:0]  be   [2];
    logic [7:0]  addr [2];
    logic [31:0] di   [2];

    logic        rdy_a, dv_a, er_a;
    logic [7:0]  do_a;
    logic        rdy_b, dv_b, er_b;
    logic [31:0] do_b;

    mem_ctrl_pipe #(
        .DATA_W(8), .ADDR_W(8), .DEPTH(256), .RD_LAT(2), .INIT_VAL(8'h00)
    ) u_dut_a (
        .clk(clk), .reset_n(rstn[0]), .ce(ce[0]), .we(we[0]), .be(be[0][0:0]),
        .addr(addr[0]), .datai(di[0][7:0]), .ready(rdy_a), .datao(do_a),
        .dvalid(dv_a), .err(er_a)
    );

    mem_ctrl_pipe #(
        .DATA_W(32), .ADDR_W(8), .DEPTH(200), .RD_LAT(3), .INIT_VAL(c_INIT_B)
    ) u_dut_b (
        .clk(clk), .reset_n(rstn[1]), .ce(ce[1]), .we(we[1]), .be(be[1]),
        .addr(addr[1]), .datai(di[1]), .ready(rdy_b), .datao(do_b),
        .dvalid(dv_b), .err(er_b)
    );

    // Reference model: word contents, edges since reset release, and the
    // expected output events keyed by the cycle they must appear in.
    logic [31:0] mdl_mem  [2][256];
    int          since_rel[2];
    bit          had_rst  [2];
    bit          pend_v   [2][8];
    bit          pend_e   [2][8];
    logic [31:0] pend_d   [2][8];
    int          cyc;
    int          nvec;
    int          nerr;

    function automatic int dep(input int i);
        return (i == 0) ? 256 : 200;
    endfunction
    function automatic int lat(input int i);
        return (i == 0) ? 2 : 3;
    endfunction
    function automatic int bew(input int i);
        return (i == 0) ? 1 : 4;
    endfunction
    function automatic logic [31:0] initv(input int i);
        return (i == 0) ? 32'h0 : c_INIT_B;
    endfunction
    function automatic logic [31:0] dmask(input int i);
        return (i == 0) ? 32'h0000_00FF : 32'hFFFF_FFFF;
    endfunction

    task automatic chk(input string tag, input int i, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s[%0d] cyc %0d: observed %h expected %h", tag, i, cyc, obs, exp);
        end
    endtask

    task automatic drive(input int i, input bit c, input bit w, input logic [3:0] b,
                         input logic [7:0] a, input logic [31:0] d);
        ce[i] = c; we[i] = w; be[i] = b; addr[i] = a; di[i] = d;
    endtask

    task automatic idle_all();
        for (int i = 0; i < 2; i++) drive(i, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    endtask

    task automatic rnd(input int i);
        logic [7:0] a;
        a = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
        drive(i, ($urandom_range(0, 9) < 7), 1'($urandom), 4'($urandom), a, $urandom);
    endtask

    task automatic apply(input int i);
        int a;
        bit oor;
        int s;
        a   = int'(addr[i]);
        oor = (a >= dep(i));
        if (we[i]) begin
            if (oor) begin
                s = (cyc + 1) % 8;
                pend_e[i][s] = 1'b1;
            end else begin
                for (int j = 0; j < bew(i); j++)
                    if (be[i][j]) mdl_mem[i][a][8*j +: 8] = di[i][8*j +: 8];
            end
        end else begin
            s = (cyc + lat(i)) % 8;
            pend_v[i][s] = 1'b1;
            pend_e[i][s] = pend_e[i][s] | oor;
            pend_d[i][s] = oor ? 32'h0 : (mdl_mem[i][a] & dmask(i));
        end
    endtask

    task automatic step();
        bit          acc [2];
        int          s;
        bit          ev, ee;
        logic [31:0] ed;
        for (int i = 0; i < 2; i++)
            acc[i] = rstn[i] && had_rst[i] && (since_rel[i] >= dep(i)) && ce[i];
        @(posedge clk);
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (!rstn[i]) begin
                had_rst[i]   = 1'b1;
                since_rel[i] = 0;
                for (int k = 0; k < 8; k++) begin
                    pend_v[i][k] = 1'b0; pend_e[i][k] = 1'b0; pend_d[i][k] = '0;
                end
                for (int k = 0; k < 256; k++) mdl_mem[i][k] = initv(i);
            end else begin
                if (acc[i]) apply(i);
                since_rel[i]++;
            end
        end
        #1;
        s = cyc % 8;
        for (int i = 0; i < 2; i++) begin
            if (had_rst[i]) begin
                ev = pend_v[i][s]; ee = pend_e[i][s]; ed = pend_d[i][s];
                chk("ready",  i, {31'b0, (i == 0) ? rdy_a : rdy_b}, {31'b0, since_rel[i] >= dep(i)});
                chk("dvalid", i, {31'b0, (i == 0) ? dv_a : dv_b}, {31'b0, ev});
                chk("err",    i, {31'b0, (i == 0) ? er_a : er_b}, {31'b0, ee});
                if (ev)
                    chk("datao", i, (i == 0) ? {24'b0, do_a} : do_b, ed);
                else if (!rstn[i])
                    chk("datao_rst", i, (i == 0) ? {24'b0, do_a} : do_b, 32'h0);
            end
            pend_v[i][s] = 1'b0; pend_e[i][s] = 1'b0;
        end
    endtask

    initial begin
        nvec = 0; nerr = 0; cyc = 0;
        for (int i = 0; i < 2; i++) begin
            rstn[i] = 1'b0; since_rel[i] = 0; had_rst[i] = 1'b0;
            for (int k = 0; k < 8; k++) begin
                pend_v[i][k] = 1'b0; pend_e[i][k] = 1'b0; pend_d[i][k] = '0;
            end
            for (int k = 0; k < 256; k++) mdl_mem[i][k] = '0;
        end
        idle_all();

        // Reset, then release with random requests that must be ignored until ready.
        repeat (10) step();
        rstn[0] = 1'b1; rstn[1] = 1'b1;
        for (int k = 0; k < 256; k++) begin
            rnd(0); rnd(1);
            step();
        end

        // Freshly initialised contents.
        idle_all();
        for (int k = 0; k < 6; k++) begin
            drive(0, 1'b1, 1'b0, 4'h0, 8'(k * 37), 32'h0);
            drive(1, 1'b1, 1'b0, 4'h0, 8'(k * 33), 32'h0);
            step();
        end
        idle_all(); repeat (5) step();

        // Write 0..15 then read back on the 8-bit instance.
        for (int k = 0; k < 16; k++) begin
            drive(0, 1'b1, 1'b1, 4'h1, 8'(k), $urandom);
            step();
        end
        for (int k = 0; k < 16; k++) begin
            drive(0, 1'b1, 1'b0, 4'h0, 8'(k), 32'h0);
            step();
        end
        idle_all(); repeat (5) step();

        // Byte-lane merge, then an immediate read-after-write.
        drive(1, 1'b1, 1'b1, 4'hF, 8'd5, 32'hAABBCCDD); step();
        drive(1, 1'b1, 1'b1, 4'h5, 8'd5, 32'h11223344); step();
        drive(1, 1'b1, 1'b0, 4'h0, 8'd5, 32'h0);        step();
        drive(1, 1'b1, 1'b1, 4'h0, 8'd5, 32'hFFFFFFFF); step();
        drive(1, 1'b1, 1'b0, 4'h0, 8'd5, 32'h0);        step();
        idle_all(); repeat (5) step();

        // Back-to-back reads of 3,4,5.
        drive(1, 1'b1, 1'b1, 4'hF, 8'd3, $urandom); step();
        drive(1, 1'b1, 1'b1, 4'hF, 8'd4, $urandom); step();
        for (int k = 3; k <= 5; k++) begin
            drive(1, 1'b1, 1'b0, 4'h0, 8'(k), 32'h0);
            step();
        end
        idle_all(); repeat (5) step();

        // Out-of-range accesses and the DEPTH boundary.
        drive(1, 1'b1, 1'b1, 4'hF, 8'hF0, 32'h12345678); step();
        drive(1, 1'b1, 1'b0, 4'h0, 8'hF0, 32'h0);        step();
        drive(1, 1'b1, 1'b1, 4'hF, 8'd199, 32'hCAFEF00D); step();
        drive(1, 1'b1, 1'b1, 4'hF, 8'd200, 32'h0BADBEEF); step();
        drive(1, 1'b1, 1'b0, 4'h0, 8'd199, 32'h0);       step();
        drive(1, 1'b1, 1'b0, 4'h0, 8'd200, 32'h0);       step();
        drive(1, 1'b1, 1'b0, 4'h0, 8'hFF, 32'h0);        step();
        idle_all(); repeat (5) step();

        // Random mixed traffic on both instances.
        for (int k = 0; k < 400; k++) begin
            rnd(0); rnd(1);
            step();
        end
        idle_all(); repeat (5) step();

        // Reset with reads in flight, then re-init.
        drive(0, 1'b1, 1'b0, 4'h0, 8'd3, 32'h0);
        drive(1, 1'b1, 1'b0, 4'h0, 8'd3, 32'h0);
        step();
        drive(0, 1'b1, 1'b0, 4'h0, 8'd4, 32'h0);
        drive(1, 1'b1, 1'b0, 4'h0, 8'd4, 32'h0);
        step();
        idle_all();
        rstn[0] = 1'b0; rstn[1] = 1'b0;
        repeat (3) step();
        rstn[0] = 1'b1; rstn[1] = 1'b1;
        repeat (256) step();
        for (int k = 0; k < 6; k++) begin
            drive(0, 1'b1, 1'b0, 4'h0, 8'(k + 1), 32'h0);
            drive(1, 1'b1, 1'b0, 4'h0, 8'(k + 1), 32'h0);
            step();
        end
        idle_all(); repeat (5) step();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
